decode_execute_reg: RTL and testbench
=====================================

DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand/PC/immediate width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 5, meaning register address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_e  in  1  hold E-stage contents
- flush_e  in  1  insert bubble into E stage
- valid_d  in  1  D-stage instruction valid
- ctrl_d  in  ctrl_t  decoded control bundle
- rd1_d, rd2_d  in  DATA_WIDTH  register file read data
- rs1_d, rs2_d, rd_d  in  ADDRESS_WIDTH  source/destination addresses
- imm_ext_d, pc_d, pc_plus4_d  in  DATA_WIDTH  immediate, PC, PC+4
- we3_w  in  1  writeback write enable (same signal driving register file WE3)
- a3_w  in  ADDRESS_WIDTH  writeback address
- wd3_w  in  DATA_WIDTH  writeback data
- valid_e, ctrl_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e  out  widths match the _d inputs  registered E-stage copies

Function
REQ-004 Priority each rising edge SHALL be rst > flush_e > stall_e > load.
REQ-005 Load (no rst/flush/stall): all _e outputs SHALL take their _d inputs after 1 cycle, with operands passed through the bypass (REQ-006/007).
REQ-006 Load bypass: operand n SHALL be 0 if rsn_d==0; else wd3_w if we3_w && a3_w!=0 && a3_w==rsn_d; else rdn_d.
REQ-007 Stall: all outputs SHALL hold, except held operand n SHALL update to wd3_w when valid_e && we3_w && a3_w!=0 && a3_w==rsn_e.
REQ-008 Flush: next state SHALL be a bubble, with valid_e=0, ctrl_e all-zero (reg_write, mem_write, jump, branch all 0), and every data/address output 0.
REQ-009 flush_e and stall_e asserted together SHALL produce a bubble; the flushed instruction is discarded.
REQ-010 valid_d=0 on load SHALL produce a bubble identical to REQ-008.
REQ-011 Writes to x0 (a3_w==0) SHALL never be bypassed, in load or stall.
REQ-012 rs1 and rs2 matching the same a3_w SHALL both receive wd3_w in the same cycle.
REQ-013 No output SHALL depend combinationally on any input; all outputs are flops.

Reset
REQ-014 On rst at a rising edge, all outputs SHALL become the bubble state of REQ-008 (valid_e=0, all fields 0).
REQ-015 Reset asserted during a stall SHALL override the stall; the held instruction is lost.
REQ-016 The first load SHALL occur on the first rising edge with rst=0, subject to REQ-004.

Structure
REQ-017 ctrl_t SHALL be a packed struct in shared package decode_pkg with fields reg_write(1), result_src(2), mem_write(1), jump(1), branch(1), alu_control(4), alu_src(1), 11 bits in total.
REQ-018 decode_pkg SHALL also hold the constants DATA_WIDTH=32, ADDRESS_WIDTH=5 and the zero-address constant.
REQ-019 Bypass selection SHALL be one sub-module, operand_bypass, instantiated once per operand and used for both the load and stall paths.

Verification
REQ-020 Load with rs1_d=3, rd1_d=0x11, we3_w=1, a3_w=3, wd3_w=0xAA -> next cycle rd1_e=0xAA.
REQ-021 Load with rs2_d=0, rd2_d=0xDEADBEEF -> rd2_e=0; we3_w=1, a3_w=0, wd3_w=5 with rs1_d=0 -> rd1_e=0.
REQ-022 Load rs1=7 (rd1_e=0x10), then stall_e=1 for 3 cycles with a writeback of a3_w=7, wd3_w=0x55 in cycle 2 -> rd1_e=0x55 from cycle 3, all other outputs unchanged, valid_e=1.
REQ-023 Valid instruction with ctrl_d.reg_write=1, mem_write=1 loaded, then flush_e=1 together with stall_e=1 -> next cycle valid_e=0, ctrl_e=0, rd_e=0.
REQ-024 rst=1 mid-stream with valid_e=1, pc_e=0x100 -> next cycle all outputs 0; after rst=0, a load of pc_d=0x200 -> pc_e=0x200 after 1 cycle.
REQ-025 rs1_d=rs2_d=9 with a same-cycle writeback of a3_w=9, wd3_w=0x1234 -> rd1_e=rd2_e=0x1234.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode-stage definitions.
//   DATA_WIDTH     default operand / PC / immediate width
//   ADDRESS_WIDTH  default register address width
//   ZERO_ADDR      address of the hard-wired zero register (x0)
//   ctrl_t         decoded control bundle carried from D into E (11 bits)
//   CTRL_NOP       all-zero control bundle used for bubbles
package decode_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/operand_bypass.sv
// Register-file read bypass for one operand.
// Ports:
//   rs_i  in   source register address
//   rd_i  in   value read for that address (or the currently held operand)
//   we_i  in   writeback write enable, already qualified by the caller
//   a3_i  in   writeback address
//   wd3_i in   writeback data
//   op_o  out  operand after bypass: 0 for x0, writeback data on a match,
//              otherwise rd_i
// Writes to x0 never bypass, so a stray writeback to x0 cannot make x0 read
// non-zero.
module operand_bypass #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0]    rd_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] a3_i,
    input  logic [DATA_WIDTH-1:0]    wd3_i,
    output logic [DATA_WIDTH-1:0]    op_o
);

    always_comb begin
        op_o = rd_i;
        if (rs_i == '0) begin
            op_o = '0;
        end else if (we_i && (a3_i != '0) && (a3_i == rs_i)) begin
            op_o = wd3_i;
        end
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode -> Execute pipeline register with writeback bypass.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_e, flush_e    hold E contents / replace them with a bubble
//   valid_d, ctrl_d     D-stage valid and control bundle
//   rd1_d, rd2_d        register file read data
//   rs1_d, rs2_d, rd_d  source / destination addresses
//   imm_ext_d, pc_d, pc_plus4_d
//   we3_w, a3_w, wd3_w  writeback port (same signals as the register file)
//   *_e                 registered E-stage copies of the D-stage fields
// Edge priority is rst > flush_e > stall_e > load. All outputs are flops.
module decode_execute_reg
    import decode_pkg::ctrl_t;
    import decode_pkg::CTRL_NOP;
#(
    parameter int DATA_WIDTH    = decode_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = decode_pkg::ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_e,
    input  logic                     flush_e,
    input  logic                     valid_d,
    input  ctrl_t                    ctrl_d,
    input  logic [DATA_WIDTH-1:0]    rd1_d,
    input  logic [DATA_WIDTH-1:0]    rd2_d,
    input  logic [ADDRESS_WIDTH-1:0] rs1_d,
    input  logic [ADDRESS_WIDTH-1:0] rs2_d,
    input  logic [ADDRESS_WIDTH-1:0] rd_d,
    input  logic [DATA_WIDTH-1:0]    imm_ext_d,
    input  logic [DATA_WIDTH-1:0]    pc_d,
    input  logic [DATA_WIDTH-1:0]    pc_plus4_d,
    input  logic                     we3_w,
    input  logic [ADDRESS_WIDTH-1:0] a3_w,
    input  logic [DATA_WIDTH-1:0]    wd3_w,
    output logic                     valid_e,
    output ctrl_t                    ctrl_e,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [ADDRESS_WIDTH-1:0] rs1_e,
    output logic [ADDRESS_WIDTH-1:0] rs2_e,
    output logic [ADDRESS_WIDTH-1:0] rd_e,
    output logic [DATA_WIDTH-1:0]    imm_ext_e,
    output logic [DATA_WIDTH-1:0]    pc_e,
    output logic [DATA_WIDTH-1:0]    pc_plus4_e
);

    logic                     valid_q;
    ctrl_t                    ctrl_q;
    logic [DATA_WIDTH-1:0]    rd1_q, rd2_q;
    logic [ADDRESS_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0]    imm_ext_q, pc_q, pc_plus4_q;

    // One bypass per operand serves both paths: while stalled it looks at the
    // held address/value so a writeback landing during the stall is not lost;
    // otherwise it looks at the incoming D-stage read. A bubble held in E must
    // not pick up writebacks, hence the valid_q qualifier on the stall path.
    logic [ADDRESS_WIDTH-1:0] rs1_sel, rs2_sel;
    logic [DATA_WIDTH-1:0]    rd1_sel, rd2_sel;
    logic                     byp_we;
    logic [DATA_WIDTH-1:0]    rd1_d_byp, rd2_d_byp;

    assign rs1_sel = stall_e ? rs1_q : rs1_d;
    assign rs2_sel = stall_e ? rs2_q : rs2_d;
    assign rd1_sel = stall_e ? rd1_q : rd1_d;
    assign rd2_sel = stall_e ? rd2_q : rd2_d;
    assign byp_we  = we3_w && (!stall_e || valid_q);

    operand_bypass #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_byp1 (
        .rs_i  (rs1_sel),
        .rd_i  (rd1_sel),
        .we_i  (byp_we),
        .a3_i  (a3_w),
        .wd3_i (wd3_w),
        .op_o  (rd1_d_byp)
    );

    operand_bypass #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_byp2 (
        .rs_i  (rs2_sel),
        .rd_i  (rd2_sel),
        .we_i  (byp_we),
        .a3_i  (a3_w),
        .wd3_i (wd3_w),
        .op_o  (rd2_d_byp)
    );

    always_ff @(posedge clk) begin
        // An invalid D-stage instruction loads as a bubble, identical to flush.
        if (rst || flush_e || (!stall_e && !valid_d)) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_ext_q  <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else if (stall_e) begin
            rd1_q <= rd1_d_byp;
            rd2_q <= rd2_d_byp;
        end else begin
            valid_q    <= 1'b1;
            ctrl_q     <= ctrl_d;
            rd1_q      <= rd1_d_byp;
            rd2_q      <= rd2_d_byp;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_ext_q  <= imm_ext_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_e    = valid_q;
    assign ctrl_e     = ctrl_q;
    assign rd1_e      = rd1_q;
    assign rd2_e      = rd2_q;
    assign rs1_e      = rs1_q;
    assign rs2_e      = rs2_q;
    assign rd_e       = rd_q;
    assign imm_ext_e  = imm_ext_q;
    assign pc_e       = pc_q;
    assign pc_plus4_e = pc_plus4_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
module tb_decode_execute_reg;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall_e, flush_e, valid_d;
    ctrl_t       ctrl_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d, wd3_w;
    logic [4:0]  rs1_d, rs2_d, rd_d, a3_w;
    logic        we3_w;
    logic        valid_e;
    ctrl_t       ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_execute_reg dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .ctrl_d(ctrl_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .imm_ext_d(imm_ext_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .we3_w(we3_w), .a3_w(a3_w), .wd3_w(wd3_w),
        .valid_e(valid_e), .ctrl_e(ctrl_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e)
    );

    // Directed vector: inputs for one edge and the outputs expected after it.
    // imm and pc+4 are derived from pc so the table stays narrow.
    typedef struct {
        bit          rst, stall, flush, valid;
        logic [10:0] ctrl;
        logic [4:0]  rs1;  logic [31:0] rd1;
        logic [4:0]  rs2;  logic [31:0] rd2;
        logic [4:0]  rd;   logic [31:0] pc;
        bit          we3;  logic [4:0]  a3;  logic [31:0] wd3;
        bit          x_valid; logic [10:0] x_ctrl;
        logic [31:0] x_rd1, x_rd2; logic [4:0] x_rd; logic [31:0] x_pc;
    } vec_t;

    function automatic vec_t v(bit r, bit s, bit f, bit vl, logic [10:0] c,
                               logic [4:0] a1, logic [31:0] d1, logic [4:0] a2, logic [31:0] d2,
                               logic [4:0] ad, logic [31:0] p, bit w, logic [4:0] wa, logic [31:0] wd,
                               bit xv, logic [10:0] xc, logic [31:0] x1, logic [31:0] x2,
                               logic [4:0] xd, logic [31:0] xp);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.valid = vl; t.ctrl = c;
        t.rs1 = a1; t.rd1 = d1; t.rs2 = a2; t.rd2 = d2; t.rd = ad; t.pc = p;
        t.we3 = w; t.a3 = wa; t.wd3 = wd;
        t.x_valid = xv; t.x_ctrl = xc; t.x_rd1 = x1; t.x_rd2 = x2; t.x_rd = xd; t.x_pc = xp;
        return t;
    endfunction

    function automatic logic [31:0] imm_of(logic [31:0] p);
        return p ^ 32'h0000_0F0F;
    endfunction

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of E: one record, updated by the edge rules directly.
    typedef struct {
        bit          valid;
        logic [10:0] ctrl;
        logic [31:0] op[2];
        logic [4:0]  rs[2];
        logic [4:0]  rd;
        logic [31:0] imm, pc, pc4;
    } estate_t;

    estate_t m;

    function automatic estate_t bubble();
        estate_t b;
        b.valid = 0; b.ctrl = '0; b.op[0] = '0; b.op[1] = '0;
        b.rs[0] = '0; b.rs[1] = '0; b.rd = '0; b.imm = '0; b.pc = '0; b.pc4 = '0;
        return b;
    endfunction

    function automatic bit hits(logic [4:0] rs);
        return we3_w && (a3_w != 5'd0) && (a3_w == rs);
    endfunction

    // Uses the current input signal values; call just before the edge.
    function automatic estate_t model_next(estate_t cur);
        estate_t n = cur;
        logic [4:0]  rsd[2];
        logic [31:0] rdd[2];
        rsd[0] = rs1_d; rsd[1] = rs2_d; rdd[0] = rd1_d; rdd[1] = rd2_d;
        if (rst || flush_e) return bubble();
        if (stall_e) begin
            for (int k = 0; k < 2; k++)
                if (cur.valid && hits(cur.rs[k])) n.op[k] = wd3_w;
            return n;
        end
        if (!valid_d) return bubble();
        n.valid = 1; n.ctrl = ctrl_d; n.rd = rd_d;
        n.imm = imm_ext_d; n.pc = pc_d; n.pc4 = pc_plus4_d;
        for (int k = 0; k < 2; k++) begin
            n.rs[k] = rsd[k];
            n.op[k] = (rsd[k] == 0) ? 32'd0 : (hits(rsd[k]) ? wd3_w : rdd[k]);
        end
        return n;
    endfunction

    function automatic logic [255:0] pack_model(estate_t s);
        return {37'd0, s.valid, s.ctrl, s.op[0], s.op[1], s.rs[0], s.rs[1], s.rd, s.imm, s.pc, s.pc4};
    endfunction

    function automatic logic [255:0] pack_dut();
        return {37'd0, valid_e, ctrl_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e};
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1; stall_e = 0; flush_e = 0; valid_d = 0; ctrl_d = '0;
        rd1_d = 0; rd2_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
        imm_ext_d = 0; pc_d = 0; pc_plus4_d = 0; we3_w = 0; a3_w = 0; wd3_w = 0;

        //          rst s f v ctrl    rs1 rd1           rs2 rd2            rd  pc          we a3 wd3          xv xctrl   xrd1          xrd2          xrd xpc
        tbl.push_back(v(1,0,0,1,11'h0A5, 3, 32'h11,      4, 32'h22,       5, 32'h40,  1, 3, 32'hAA,   0, 11'h000, 32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(0,0,0,1,11'h0A5, 3, 32'h11,      4, 32'h22,       5, 32'h40,  1, 3, 32'hAA,   1, 11'h0A5, 32'hAA,       32'h22,       5, 32'h40));
        tbl.push_back(v(0,0,0,1,11'h123, 0, 32'h77,      0, 32'hDEADBEEF, 6, 32'h44,  1, 0, 32'h5,    1, 11'h123, 32'h0,        32'h0,        6, 32'h44));
        tbl.push_back(v(0,0,0,1,11'h321, 9, 32'h1,       9, 32'h2,        7, 32'h48,  1, 9, 32'h1234, 1, 11'h321, 32'h1234,     32'h1234,     7, 32'h48));
        tbl.push_back(v(0,0,0,1,11'h222, 8, 32'h33,     10, 32'h44,       8, 32'h4C,  0, 8, 32'h99,   1, 11'h222, 32'h33,       32'h44,       8, 32'h4C));
        tbl.push_back(v(0,0,0,0,11'h7FF, 8, 32'h33,     10, 32'h44,       8, 32'h4C,  0, 0, 32'h0,    0, 11'h000, 32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(0,0,0,1,11'h7FF, 7, 32'h10,      2, 32'h20,       1, 32'h50,  0, 0, 32'h0,    1, 11'h7FF, 32'h10,       32'h20,       1, 32'h50));
        tbl.push_back(v(0,1,0,1,11'h001, 1, 32'hFFFF,    3, 32'hEEEE,     9, 32'h999, 0, 7, 32'h44,   1, 11'h7FF, 32'h10,       32'h20,       1, 32'h50));
        tbl.push_back(v(0,1,0,1,11'h001, 1, 32'hFFFF,    3, 32'hEEEE,     9, 32'h999, 1, 7, 32'h55,   1, 11'h7FF, 32'h55,       32'h20,       1, 32'h50));
        tbl.push_back(v(0,1,0,1,11'h001, 0, 32'hFFFF,    0, 32'hEEEE,     9, 32'h999, 1, 0, 32'h66,   1, 11'h7FF, 32'h55,       32'h20,       1, 32'h50));
        tbl.push_back(v(0,1,0,1,11'h001, 1, 32'hFFFF,    3, 32'hEEEE,     9, 32'h999, 1, 2, 32'h77,   1, 11'h7FF, 32'h55,       32'h77,       1, 32'h50));
        tbl.push_back(v(0,1,1,1,11'h7FF, 1, 32'h1,       2, 32'h2,        3, 32'h60,  1, 1, 32'h88,   0, 11'h000, 32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(0,0,0,1,11'h0A5, 1, 32'h5,       2, 32'h6,        3, 32'h100, 0, 0, 32'h0,    1, 11'h0A5, 32'h5,        32'h6,        3, 32'h100));
        tbl.push_back(v(1,1,0,1,11'h0A5, 1, 32'h5,       2, 32'h6,        3, 32'h104, 1, 1, 32'h9,    0, 11'h000, 32'h0,        32'h0,        0, 32'h0));
        tbl.push_back(v(0,0,0,1,11'h001, 4, 32'h8,       0, 32'h9,        2, 32'h200, 0, 0, 32'h0,    1, 11'h001, 32'h8,        32'h0,        2, 32'h200));
        tbl.push_back(v(0,0,1,1,11'h7FF, 4, 32'h8,       5, 32'h9,        2, 32'h204, 0, 0, 32'h0,    0, 11'h000, 32'h0,        32'h0,        0, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            logic [255:0] exp_v, act_v;
            rst = tbl[i].rst; stall_e = tbl[i].stall; flush_e = tbl[i].flush;
            valid_d = tbl[i].valid; ctrl_d = tbl[i].ctrl;
            rs1_d = tbl[i].rs1; rd1_d = tbl[i].rd1; rs2_d = tbl[i].rs2; rd2_d = tbl[i].rd2;
            rd_d = tbl[i].rd; pc_d = tbl[i].pc; imm_ext_d = imm_of(tbl[i].pc); pc_plus4_d = tbl[i].pc + 32'd4;
            we3_w = tbl[i].we3; a3_w = tbl[i].a3; wd3_w = tbl[i].wd3;
            step();
            exp_v = {tbl[i].x_valid, tbl[i].x_ctrl, tbl[i].x_rd1, tbl[i].x_rd2, tbl[i].x_rd,
                     tbl[i].x_valid ? imm_of(tbl[i].x_pc) : 32'd0, tbl[i].x_pc,
                     tbl[i].x_valid ? tbl[i].x_pc + 32'd4 : 32'd0};
            act_v = {valid_e, ctrl_e, rd1_e, rd2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e};
            check($sformatf("vec%0d", i), act_v, exp_v);
        end

        // Random phase: small address space so bypass hits are frequent.
        rst = 1; step();
        m = bubble();
        check("rand_reset", pack_dut(), pack_model(m));
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flush_e    = ($urandom_range(0, 9) == 0);
            stall_e    = ($urandom_range(0, 3) == 0);
            valid_d    = ($urandom_range(0, 4) != 0);
            ctrl_d     = 11'($urandom);
            rs1_d      = 5'($urandom_range(0, 3));
            rs2_d      = 5'($urandom_range(0, 3));
            rd_d       = 5'($urandom);
            rd1_d      = $urandom; rd2_d = $urandom;
            imm_ext_d  = $urandom; pc_d = $urandom; pc_plus4_d = $urandom;
            we3_w      = $urandom_range(0, 1);
            a3_w       = 5'($urandom_range(0, 3));
            wd3_w      = $urandom;
            m = model_next(m);
            step();
            check($sformatf("rand%0d", i), pack_dut(), pack_model(m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
